// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: owns the PC, reads a combinational imem
// port and buffers {instr, pc} in a DEPTH-entry FIFO. Optional FETCH_HALT_EN halts on a zero word.
module fetch_queue #(
    parameter int unsigned              ADDR_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH = 32,
    parameter int unsigned              DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_en,
    input  logic                          redirect_valid,
    input  logic [ADDR_WIDTH-1:0]         redirect_target,
    output logic [ADDR_WIDTH-1:0]         imem_addr,
    input  logic [DATA_WIDTH-1:0]         imem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_instr,
    output logic [ADDR_WIDTH-1:0]         out_pc,
    output logic [ADDR_WIDTH-1:0]         out_pc_plus8,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          halted
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];

    logic empty, full, pop, can_push, push, running, stop;

    // Target low bits are dropped: the PC is always word aligned.
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_target[1:0];

    assign empty     = (cnt == '0);
    assign full      = (cnt == FULL);
    assign out_valid = !empty && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign can_push  = running && fetch_en && !redirect_valid && (!full || pop);
    assign push      = can_push && !stop;
    assign imem_addr = pc;
    assign count     = cnt;

`ifdef FETCH_HALT_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t state;
    logic   halted_r;

    assign running = (state == RUN);
    assign stop    = can_push && (imem_rdata == '0);
    assign halted  = halted_r;

    // Halt on a zero word; only a redirect brings fetch back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            halted_r <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (stop) begin
                        state    <= HALT;
                        halted_r <= 1'b1;
                    end
                end
                HALT: begin
                    if (redirect_valid) begin
                        state    <= RUN;
                        halted_r <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end
`else
    assign running = 1'b1;
    assign stop    = 1'b0;
    assign halted  = 1'b0;
`endif

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_target[ADDR_WIDTH-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                pc     <= pc + ADDR_WIDTH'(4);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt_nxt;
        end
    end

    // Storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]    <= pc;
        end
    end

    assign out_instr    = empty ? '0 : instr_q[rd_ptr];
    assign out_pc       = empty ? '0 : pc_q[rd_ptr];
    assign out_pc_plus8 = empty ? '0 : pc_q[rd_ptr] + ADDR_WIDTH'(8);

endmodule
